// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and memory arbiter.
// Latency: hit is combinational (same cycle); miss is 1 cycle to FETCH + wait cycles + 1 cycle to hit.
// Backpressure: fetch stalls (ihit=0) while a fill is pending on iwait; flush aborts any fill.
// Optional ICACHE_STATS_EN macro adds hit_count/miss_count outputs.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       state, next_state;
  logic [31:0]      miss_addr;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit;
  logic             miss_go;
  logic             fill_we;
  logic             unused_addr_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];
  // Byte offset is irrelevant for word fetches.
  assign unused_addr_bits = ^imemaddr[1:0];

  assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

  // flush wins over everything: no hit reported, no miss started, no line written.
  assign ihit     = (state == IDLE) && imemREN && lookup_hit && !flush;
  assign imemload = ihit ? data[req_idx] : 32'h0;
  assign miss_go  = (state == IDLE) && imemREN && !lookup_hit && !flush;
  assign fill_we  = (state == FETCH) && !iwait && !flush;

  assign iREN  = (state == FETCH);
  assign iaddr = (state == FETCH) ? miss_addr : 32'h0;

  // Next-state: IDLE -> FETCH on a miss, FETCH -> IDLE when memory answers; flush forces IDLE.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else if (state == IDLE) begin
      if (miss_go) next_state = FETCH;
    end else begin
      if (!iwait) next_state = IDLE;
    end
  end

  // State, miss address and valid bits; valid is the only line storage that needs reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (miss_go) miss_addr <= {imemaddr[31:2], 2'b00};
      if (flush) begin
        valid <= '0;
      end else if (fill_we) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: a fill overwrites the indexed line unconditionally.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Performance counters: free-running, wrap naturally, survive flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit)    hit_count  <= hit_count + 32'd1;
      if (miss_go) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
